// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand-forward select and load-use stall generator for an
// RV32I pipeline. It sits beside decode and tracks a shadow of the last
// FWD_DEPTH issued instructions (valid, rd, is_load). Entry 0 is the youngest (EX).
module hazard_fwd_ctrl #(
    parameter int ILEN      = 32,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16,
    localparam int FSEL_W   = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ILEN-1:0]   id_instr,
    input  logic              id_valid,
    input  logic              adv,
    input  logic              flush,
    output logic [FSEL_W-1:0] fwd_sela,
    output logic [FSEL_W-1:0] fwd_selb,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [6:0]           opcode_s;
    logic                 use1_s, use2_s, wr_s;
    logic                 is_load_s;
    logic [4:0]           rs1_s, rs2_s, rd_s;
    logic                 unused_bits_s;

    logic [FWD_DEPTH-1:0] sh_v_r;
    logic [FWD_DEPTH-1:0] sh_ld_r;
    logic [4:0]           sh_rd_r [FWD_DEPTH];

    logic [FSEL_W-1:0]    sel1_s, sel2_s;
    logic                 hz1_s, hz2_s;
    logic                 stall_s, bubble_s;
    logic [CNT_W-1:0]     stall_cnt_r;

    assign opcode_s      = id_instr[6:0];
    assign unused_bits_s = ^{id_instr[ILEN-1:25], id_instr[14:12]};

    // Classify the decode instruction: which source fields it reads, whether it writes rd.
    always_comb begin
        use1_s    = 1'b0;
        use2_s    = 1'b0;
        wr_s      = 1'b0;
        is_load_s = (opcode_s == OP_LOAD);
        case (opcode_s)
            OP_R:     begin use1_s = 1'b1; use2_s = 1'b1; wr_s = 1'b1; end
            OP_I:     begin use1_s = 1'b1; wr_s = 1'b1; end
            OP_LOAD:  begin use1_s = 1'b1; wr_s = 1'b1; end
            OP_S:     begin use1_s = 1'b1; use2_s = 1'b1; end
            OP_B:     begin use1_s = 1'b1; use2_s = 1'b1; end
            OP_JALR:  begin use1_s = 1'b1; wr_s = 1'b1; end
            OP_LUI:   begin wr_s = 1'b1; end
            OP_AUIPC: begin wr_s = 1'b1; end
            OP_JAL:   begin wr_s = 1'b1; end
            default:  begin use1_s = 1'b0; use2_s = 1'b0; wr_s = 1'b0; end
        endcase
        rs1_s = use1_s ? id_instr[19:15] : 5'd0;
        rs2_s = use2_s ? id_instr[24:20] : 5'd0;
        rd_s  = wr_s   ? id_instr[11:7]  : 5'd0;
    end

    // Youngest-match search: scan oldest to youngest so the youngest match is kept last.
    always_comb begin
        sel1_s = {FSEL_W{1'b0}};
        sel2_s = {FSEL_W{1'b0}};
        hz1_s  = 1'b0;
        hz2_s  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (sh_v_r[k] && (sh_rd_r[k] != 5'd0) && (sh_rd_r[k] == rs1_s)) begin
                sel1_s = FSEL_W'(k + 1);
                hz1_s  = sh_ld_r[k] && (k < LOAD_LAT);
            end else begin
                sel1_s = sel1_s;
                hz1_s  = hz1_s;
            end
            if (sh_v_r[k] && (sh_rd_r[k] != 5'd0) && (sh_rd_r[k] == rs2_s)) begin
                sel2_s = FSEL_W'(k + 1);
                hz2_s  = sh_ld_r[k] && (k < LOAD_LAT);
            end else begin
                sel2_s = sel2_s;
                hz2_s  = hz2_s;
            end
        end
    end

    // Stall/bubble and gated forward selects; flush suppresses the stall.
    always_comb begin
        stall_s  = id_valid & ~flush & (hz1_s | hz2_s);
        bubble_s = stall_s | flush;
        if (id_valid && !stall_s) begin
            fwd_sela = sel1_s;
            fwd_selb = sel2_s;
        end else begin
            fwd_sela = {FSEL_W{1'b0}};
            fwd_selb = {FSEL_W{1'b0}};
        end
    end

    assign stall     = stall_s;
    assign bubble    = bubble_s;
    assign stall_cnt = stall_cnt_r;

    // Shadow pipeline: shift on advance, insert the decode instruction (or a bubble) at entry 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_v_r  <= {FWD_DEPTH{1'b0}};
            sh_ld_r <= {FWD_DEPTH{1'b0}};
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sh_rd_r[k] <= 5'd0;
            end
        end else if (adv) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                sh_v_r[k]  <= sh_v_r[k-1];
                sh_rd_r[k] <= sh_rd_r[k-1];
                sh_ld_r[k] <= sh_ld_r[k-1];
            end
            sh_v_r[0]  <= id_valid & ~bubble_s;
            sh_rd_r[0] <= rd_s;
            sh_ld_r[0] <= is_load_s;
        end else begin
            sh_v_r  <= sh_v_r;
            sh_ld_r <= sh_ld_r;
        end
    end

    // Saturating count of stall cycles that actually advanced.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && adv && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; dut uses LOAD_LAT=1, dut2 uses LOAD_LAT=2.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid, adv, flush;
    logic [1:0]  fwd_sela, fwd_selb, fwd_sela2, fwd_selb2;
    logic        stall, bubble, stall2, bubble2;
    logic [15:0] stall_cnt, stall_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    hazard_fwd_ctrl #(.ILEN(32), .FWD_DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .adv(adv), .flush(flush), .fwd_sela(fwd_sela), .fwd_selb(fwd_selb),
        .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.ILEN(32), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .adv(adv), .flush(flush), .fwd_sela(fwd_sela2), .fwd_selb(fwd_selb2),
        .stall(stall2), .bubble(bubble2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic [31:0] ins, input logic v, input logic a, input logic f);
        id_instr = ins;
        id_valid = v;
        adv      = a;
        flush    = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(32'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset held 2 cycles with a live instruction in decode.
        rst = 1'b0;
        drive(r_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        drive(r_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0);
        check_eq("rst_sela", fwd_sela, 0);
        check_eq("rst_selb", fwd_selb, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_bubble", bubble, 0);
        check_eq("rst_cnt", stall_cnt, 0);

        // Both operands RAW on the instruction in EX.
        do_reset();
        drive(r_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
        tick();
        drive(r_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0);
        check_eq("raw_sela", fwd_sela, 1);
        check_eq("raw_selb", fwd_selb, 1);
        check_eq("raw_stall", stall, 0);

        // Distance 3 (WB) forwards; distance 4 falls out of the shadow.
        do_reset();
        drive(i_addi(5'd7, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(i_addi(5'd10, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(i_addi(5'd11, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd12, 5'd7, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("dist3_sela", fwd_sela, 3);
        check_eq("dist3_selb", fwd_selb, 0);
        drive(i_addi(5'd13, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd12, 5'd0, 5'd7), 1'b1, 1'b1, 1'b0);
        check_eq("dist4_selb", fwd_selb, 0);

        // Youngest writer wins.
        do_reset();
        drive(i_addi(5'd7, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(i_addi(5'd7, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd12, 5'd7, 5'd7), 1'b1, 1'b1, 1'b0);
        check_eq("prio_sela", fwd_sela, 1);
        check_eq("prio_selb", fwd_selb, 1);

        // Invalid decode never forwards.
        drive(r_add(5'd12, 5'd7, 5'd7), 1'b0, 1'b1, 1'b0);
        check_eq("inval_sela", fwd_sela, 0);

        // Load-use with LOAD_LAT=1: one stall cycle, then forward from entry 1.
        do_reset();
        drive(i_lw(5'd8, 5'd1), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("lu_stall", stall, 1);
        check_eq("lu_bubble", bubble, 1);
        check_eq("lu_sela_stall", fwd_sela, 0);
        tick();
        check_eq("lu_stall_done", stall, 0);
        check_eq("lu_bubble_done", bubble, 0);
        check_eq("lu_sela", fwd_sela, 2);
        check_eq("lu_cnt", stall_cnt, 1);

        // Load-use with LOAD_LAT=2 (dut2): two stall cycles, then select 3.
        do_reset();
        drive(i_lw(5'd8, 5'd1), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("ll2_stall_a", stall2, 1);
        tick();
        check_eq("ll2_stall_b", stall2, 1);
        check_eq("ll2_cnt_mid", stall_cnt2, 1);
        tick();
        check_eq("ll2_stall_done", stall2, 0);
        check_eq("ll2_sela", fwd_sela2, 3);
        check_eq("ll2_cnt", stall_cnt2, 2);

        // Flush in the stall cycle: no stall, bubble issued, nothing counted.
        do_reset();
        drive(i_lw(5'd8, 5'd1), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b1);
        check_eq("fl_stall", stall, 0);
        check_eq("fl_bubble", bubble, 1);
        tick();
        drive(r_add(5'd10, 5'd9, 5'd8), 1'b1, 1'b1, 1'b0);
        check_eq("fl_e0_invalid", fwd_sela, 0);
        check_eq("fl_load_e1", fwd_selb, 2);
        check_eq("fl_cnt", stall_cnt, 0);

        // x0 never matches.
        do_reset();
        drive(i_addi(5'd0, 5'd0), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd12, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("x0_sela", fwd_sela, 0);
        check_eq("x0_selb", fwd_selb, 0);

        // Freeze during a load-use stall holds state and counter.
        do_reset();
        drive(i_lw(5'd8, 5'd1), 1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0);
            check_eq("frz_stall", stall, 1);
            check_eq("frz_cnt", stall_cnt, 0);
            tick();
        end
        drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("frz_stall_adv", stall, 1);
        tick();
        check_eq("frz_cnt_after", stall_cnt, 1);
        check_eq("frz_stall_done", stall, 0);
        check_eq("frz_sela", fwd_sela, 2);

        // Reset in the middle of a stall clears it next cycle.
        drive(i_lw(5'd8, 5'd1), 1'b1, 1'b1, 1'b0); tick();
        drive(r_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0);
        check_eq("rstmid_stall", stall, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("rstmid_stall_clr", stall, 0);
        check_eq("rstmid_cnt", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised forwarding and hazard controller for the RV32I pipeline. It sits beside the decode stage.
- Keeps an internal shadow of the last FWD_DEPTH issued instructions, holding valid, rd and is_load for each.
- Each cycle it produces a multi-bit operand-forward select for rs1 and rs2, plus a load-use stall and a bubble request.
- Honours branch flush and global pipeline freeze, and counts stall cycles for performance tracking.

Parameters:
- ILEN, 32: instruction width.
- FWD_DEPTH, 3: downstream stages tracked (EX, MEM, WB). Legal range 1..4.
- LOAD_LAT, 1: a load in shadow entry k with k < LOAD_LAT cannot forward and forces a stall. Legal range 0..FWD_DEPTH.
- CNT_W, 16: stall counter width.
- FSEL_W = $clog2(FWD_DEPTH+1): derived localparam, forward select width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset.
- id_instr, input, ILEN: instruction currently in decode.
- id_valid, input, 1: id_instr is a real instruction (0 = bubble).
- adv, input, 1: pipeline advance enable. 0 = global freeze.
- flush, input, 1: taken branch or jump resolved; kills the decode instruction.
- fwd_sela, output, FSEL_W: rs1 source. 0 = register file; k = shadow entry k-1.
- fwd_selb, output, FSEL_W: rs2 source, same encoding.
- stall, output, 1: hold PC and IF/ID register.
- bubble, output, 1: next entry issued to EX is a NOP.
- stall_cnt, output, CNT_W: saturating count of stall cycles.

Behaviour:
- Decode of id_instr (combinational):
  - rs1 is used by R, I, ILOAD, S, B and JALR.
  - rs2 is used by R, S and B.
  - rd is written by R, I, ILOAD, LUI, AUIPC, JAL and JALR.
  - is_load = (opcode == 7'b0000011).
  - Unused fields are forced to 5'd0.
  - Any unrecognised opcode counts as no use and no write.
- Shadow entries E[0..FWD_DEPTH-1], where E[0] is youngest (in EX). Each holds {v, rd, ld}.
- Match rule: E[k] matches rsX iff E[k].v, E[k].rd != 0 and E[k].rd == rsX. x0 never matches.
- Forward select (combinational):
  - fwd_selX = k+1 for the smallest matching k, i.e. the youngest entry wins.
  - fwd_selX = 0 if there is no match, or if id_valid = 0.
  - rs1 and rs2 are evaluated independently. Both may be non-zero in the same cycle.
- Load-use stall (combinational):
  - stall = id_valid & !flush & (a used rsX has its youngest match at entry k with E[k].ld and k < LOAD_LAT).
  - bubble = stall | flush.
  - fwd_sela = fwd_selb = 0 whenever stall = 1.
- Update on posedge clk:
  - If rst == 0: all E[k].v = 0 and stall_cnt = 0. With no valid entries, every output reads 0 in the cycle after reset.
  - Else if adv == 0: hold all state. Outputs are re-evaluated on unchanged state.
  - Else (adv == 1):
    - E[k] <= E[k-1] for k >= 1.
    - E[0] <= {id_valid & !bubble, rd, is_load}.
    - If bubble = 1, E[0].v <= 0.
- Stall is self-sequencing. After the inserted bubble the load moves to E[1]. The same decode instruction is re-evaluated and then forwards with select = LOAD_LAT+1.
- Stall counter:
  - stall_cnt increments when stall & adv & rst.
  - It saturates at all-ones, with no wrap.
- Simultaneous events:
  - flush wins over stall: stall = 0, bubble = 1, no count.
  - Freeze (adv = 0) wins over everything except reset.
  - Reset in the middle of a stall clears it in the next cycle.
- Latency: forward select and stall are valid in the same cycle id_instr is presented. The shadow updates one cycle later.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with add x5,x1,x2 and id_valid = 1. Then release and present add x6,x5,x5 → fwd_sela = 0, fwd_selb = 0, stall = 0, stall_cnt = 0.
- Both-operand RAW: add x5,x1,x2, then next cycle add x6,x5,x5 → fwd_sela = 1 and fwd_selb = 1 in the same cycle.
- Distance and priority:
  - addi x7 then 2 unrelated instructions, then use x7 → sel = 3.
  - With 3 unrelated instructions between → sel = 0.
  - addi x7 twice, back to back, then use x7 → sel = 1 (youngest wins).
- Load-use:
  - lw x8, then add x9,x8,x0 → stall = 1 and bubble = 1 for exactly 1 cycle, then fwd_sela = 2, stall_cnt = 1.
  - With LOAD_LAT = 2 → 2 stall cycles, then sel = 3, stall_cnt = 2.
- Flush during stall: lw x8, then add x9,x8 with flush = 1 in the stall cycle → stall = 0, bubble = 1, E[0] invalid, stall_cnt unchanged.
- x0 and freeze:
  - addi x0 then use x0 → sel = 0.
  - lw x8 then add x9,x8 with adv = 0 for 3 cycles → stall stays 1, shadow unchanged, stall_cnt unchanged until adv = 1.
